// File: rtl/magia_eoc_collector.sv
// End-of-computation collector: after an arm pulse it captures each tile's EOC
// flag and exit code once, applies an optional cycle timeout and reports one
// aggregated done/exit status.
module magia_eoc_collector #(
  parameter int unsigned       N_TILES      = 4,
  parameter int unsigned       EXIT_W       = 32,
  parameter int unsigned       TIMEOUT_W    = 32,
  parameter logic [EXIT_W-1:0] TIMEOUT_CODE = '1,
  parameter int unsigned       IDX_W        = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [TIMEOUT_W-1:0]        timeout_cycles_i,
  input  logic [N_TILES-1:0]          tile_eoc_i,
  input  logic [N_TILES*EXIT_W-1:0]   tile_exit_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic [EXIT_W-1:0]           exit_code_o,
  output logic [IDX_W-1:0]            fail_idx_o,
  output logic                        fail_valid_o,
  output logic [N_TILES-1:0]          eoc_mask_o,
  output logic [1:0]                  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Interface contract: start_i is a single-cycle pulse honoured only in IDLE
  // or DONE; tile_exit_i slices are only looked at while the matching
  // tile_eoc_i bit is high and that tile has not yet been captured.

  state_t               r_state;
  logic [N_TILES-1:0]   r_mask;
  logic [EXIT_W-1:0]    r_codes [N_TILES];
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] r_limit;
  logic                 r_timeout;

  logic [N_TILES-1:0]   w_mask_next;
  logic                 w_complete;
  logic                 w_limit_hit;
  logic                 w_fail_valid;
  logic [IDX_W-1:0]     w_fail_idx;
  logic [EXIT_W-1:0]    w_fail_code;

  always_comb begin
    w_mask_next = r_mask | tile_eoc_i;
    w_complete  = &w_mask_next;
    w_limit_hit = (r_limit != '0) && (r_cnt == (r_limit - TIMEOUT_W'(1)));
  end

  // Walk from the top down so the lowest-index failing tile wins.
  always_comb begin
    w_fail_valid = 1'b0;
    w_fail_idx   = '0;
    w_fail_code  = '0;
    for (int t = N_TILES - 1; t >= 0; t--) begin
      if (r_mask[t] && (r_codes[t] != '0)) begin
        w_fail_valid = 1'b1;
        w_fail_idx   = IDX_W'(t);
        w_fail_code  = r_codes[t];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_limit   <= '0;
      r_timeout <= 1'b0;
      for (int t = 0; t < N_TILES; t++) r_codes[t] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state   <= S_RUN;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_limit   <= timeout_cycles_i;
            r_timeout <= 1'b0;
            for (int t = 0; t < N_TILES; t++) r_codes[t] <= '0;
          end
        end
        S_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + TIMEOUT_W'(1);
          for (int t = 0; t < N_TILES; t++) begin
            if (tile_eoc_i[t] && !r_mask[t]) r_codes[t] <= tile_exit_i[t*EXIT_W +: EXIT_W];
          end
          r_mask <= w_mask_next;
          // Completion has priority over a timeout landing on the same edge.
          if (w_complete) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b0;
          end else if (w_limit_hit) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o       = (r_state == S_RUN);
    done_o       = (r_state == S_DONE);
    timeout_o    = r_timeout;
    eoc_mask_o   = r_mask;
    dbg_state_o  = r_state;
    fail_valid_o = (r_state != S_IDLE) && w_fail_valid;
    fail_idx_o   = (r_state != S_IDLE) ? w_fail_idx : '0;
    exit_code_o  = '0;
    if (r_state == S_DONE) exit_code_o = r_timeout ? TIMEOUT_CODE : w_fail_code;
  end

endmodule

// File: tb/tb_magia_eoc_collector.sv
// Directed bench for magia_eoc_collector: completion, error aggregation,
// timeout, completion/timeout tie, capture-once, restart and async reset.
module tb_magia_eoc_collector;

  localparam int N = 4;
  localparam int EW = 32;
  localparam int TW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [TW-1:0] timeout_cycles_i = '0;
  logic [N-1:0]  tile_eoc_i = '0;
  logic [N*EW-1:0] tile_exit_i = '0;
  logic          busy_o, done_o, timeout_o, fail_valid_o;
  logic [EW-1:0] exit_code_o;
  logic [1:0]    fail_idx_o;
  logic [N-1:0]  eoc_mask_o;
  logic [1:0]    dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  magia_eoc_collector #(.N_TILES(N), .EXIT_W(EW), .TIMEOUT_W(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .timeout_cycles_i(timeout_cycles_i), .tile_eoc_i(tile_eoc_i),
    .tile_exit_i(tile_exit_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .exit_code_o(exit_code_o), .fail_idx_o(fail_idx_o),
    .fail_valid_o(fail_valid_o), .eoc_mask_o(eoc_mask_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_code(input int t, input logic [EW-1:0] v);
    tile_exit_i[t*EW +: EW] = v;
  endtask

  task automatic arm(input logic [TW-1:0] limit);
    timeout_cycles_i = limit;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic to, input logic [EW-1:0] code,
                            input logic fv, input logic [1:0] fi, input logic [N-1:0] mask);
    check({tag, "_done"}, done_o, 1'b1);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_timeout"}, timeout_o, to);
    check({tag, "_exit"}, exit_code_o, code);
    check({tag, "_fvalid"}, fail_valid_o, fv);
    check({tag, "_fidx"}, fail_idx_o, fi);
    check({tag, "_mask"}, eoc_mask_o, mask);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_timeout"}, timeout_o, 1'b0);
    check({tag, "_exit"}, exit_code_o, '0);
    check({tag, "_fvalid"}, fail_valid_o, 1'b0);
    check({tag, "_fidx"}, fail_idx_o, '0);
    check({tag, "_mask"}, eoc_mask_o, '0);
  endtask

  initial begin
    #12;
    check_zero("reset");
    rst_ni = 1'b1;
    tick();
    tick();
    check_zero("idle");

    // Basic completion: EOCs at RUN cycles 3, 5, 5, 9, all codes zero
    arm(32'd0);
    check("basic_start_busy", busy_o, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) tile_eoc_i[0] = 1'b1;
      if (c == 5) tile_eoc_i[2:1] = 2'b11;
      if (c == 9) tile_eoc_i[3] = 1'b1;
      tick();
      if (c == 5) check("basic_mask_c5", eoc_mask_o, 4'b0111);
      if (c == 8) check("basic_busy_c8", busy_o, 1'b1);
    end
    check_done("basic", 1'b0, 32'h0, 1'b0, 2'd0, 4'b1111);

    // Error aggregation, restarted from DONE
    tile_eoc_i = '0;
    set_code(0, 32'h0); set_code(1, 32'h11); set_code(2, 32'h0); set_code(3, 32'h7);
    arm(32'd0);
    check("agg_restart_mask", eoc_mask_o, 4'b0000);
    check("agg_restart_busy", busy_o, 1'b1);
    check("agg_restart_fvalid", fail_valid_o, 1'b0);
    tile_eoc_i = 4'b1111;
    tick();
    check_done("agg", 1'b0, 32'h11, 1'b1, 2'd1, 4'b1111);

    // Timeout 20 with tiles 0,2 silent; a start pulse mid-RUN must be ignored
    tile_eoc_i = '0;
    set_code(0, 32'h0); set_code(1, 32'h0); set_code(2, 32'h0); set_code(3, 32'h7);
    arm(32'd20);
    check("to_timeout_cleared", timeout_o, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) tile_eoc_i = 4'b1010;
      start_i = (c == 10);
      tick();
      start_i = 1'b0;
      if (c == 19) check("to_busy_c19", busy_o, 1'b1);
      if (c == 19) check("to_done_c19", done_o, 1'b0);
    end
    check_done("to", 1'b1, 32'hFFFF_FFFF, 1'b1, 2'd3, 4'b1010);
    tick();
    check("to_hold_exit", exit_code_o, 32'hFFFF_FFFF);

    // Tie: last EOC on the 6th RUN cycle with limit 6 -> completion wins
    tile_eoc_i = '0;
    set_code(0, 32'h0); set_code(1, 32'h0); set_code(2, 32'h22); set_code(3, 32'h0);
    arm(32'd6);
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) tile_eoc_i = 4'b0111;
      if (c == 6) tile_eoc_i = 4'b1111;
      tick();
    end
    check_done("tie", 1'b0, 32'h22, 1'b1, 2'd2, 4'b1111);

    // Capture-once: tile1 reports 0x5, drops, re-asserts with 0x9
    tile_eoc_i = '0;
    set_code(0, 32'h0); set_code(1, 32'h5); set_code(2, 32'h0); set_code(3, 32'h0);
    arm(32'd0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) tile_eoc_i[1] = 1'b1;
      if (c == 2) tile_eoc_i[1] = 1'b0;
      if (c == 3) begin tile_eoc_i[1] = 1'b1; set_code(1, 32'h9); end
      if (c == 4) tile_eoc_i = 4'b1111;
      tick();
      if (c == 2) check("once_mask_after_drop", eoc_mask_o, 4'b0010);
    end
    check_done("once", 1'b0, 32'h5, 1'b1, 2'd1, 4'b1111);

    // Async reset mid-RUN with two tiles captured
    tile_eoc_i = '0;
    set_code(0, 32'h3); set_code(1, 32'h0); set_code(2, 32'h0); set_code(3, 32'h0);
    arm(32'd0);
    tile_eoc_i = 4'b0011;
    tick();
    check("rst_pre_mask", eoc_mask_o, 4'b0011);
    check("rst_pre_fvalid", fail_valid_o, 1'b1);
    #3 rst_ni = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tile_eoc_i = 4'b1111;
    for (int c = 0; c < 3; c++) tick();
    check_zero("rst_idle");
    arm(32'd0);
    check("rst_rearm_busy", busy_o, 1'b1);
    tick();
    check_done("rst_rerun", 1'b0, 32'h3, 1'b1, 2'd0, 4'b1111);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/magia_eoc_collector.md
# magia_eoc_collector

Synthesizable end-of-computation collector for a multi-tile MAGIA cluster. Software first arms it; it then latches each tile's EOC flag and exit code, applies an optional cycle timeout, and reports one aggregated done/exit status. The bench reads this status instead of polling each tile. It sits between the tile array and the simulation/host control interface.

## Interface
- N_TILES, default 4: number of tiles monitored (≥1).
- EXIT_W, default 32: exit-code width per tile.
- TIMEOUT_W, default 32: timeout counter width.
- TIMEOUT_CODE, default all-ones (EXIT_W bits): exit code reported on timeout.
- IDX_W, default max(1, $clog2(N_TILES)): tile index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle arm pulse.
- timeout_cycles_i  in  TIMEOUT_W  timeout limit, sampled on start; 0 disables the timeout.
- tile_eoc_i  in  N_TILES  per-tile EOC level.
- tile_exit_i  in  N_TILES*EXIT_W  per-tile exit codes, tile t at bits [t*EXIT_W +: EXIT_W]; valid while that tile's EOC bit is high.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- timeout_o  out  1  DONE was reached by timeout.
- exit_code_o  out  EXIT_W  aggregated exit code.
- fail_idx_o  out  IDX_W  lowest-index tile with a nonzero captured code.
- fail_valid_o  out  1  at least one captured code is nonzero.
- eoc_mask_o  out  N_TILES  tiles captured so far.

## Operation
- States: IDLE, RUN, DONE. All registers reset to 0 and the state resets to IDLE, so every output is 0 after reset.
- IDLE + start_i → RUN. On that edge: clear the mask, the captured codes and the counter; latch timeout_cycles_i.
- DONE + start_i → RUN, with the same clearing. start_i in RUN is ignored.
- RUN, per cycle, for each tile t with tile_eoc_i[t]=1 and mask[t]=0:
  - capture the tile's code;
  - set mask[t].
  - A tile is captured only once. Later toggles of its EOC or changes to its code are ignored until the next start.
- RUN: the counter increments each cycle and saturates at its maximum.
- Completion: if the mask after the update is all ones, go to DONE with timeout_o=0.
- Timeout: if the latched limit is nonzero and the counter equals limit−1 on this edge (no completion), go to DONE with timeout_o=1.
  - The RUN duration is therefore exactly limit cycles.
  - If completion and timeout fall on the same edge, completion wins.
- exit_code_o, valid in DONE:
  - on timeout: TIMEOUT_CODE;
  - otherwise: the code of the lowest-index tile with a nonzero captured code, or 0 if all codes are zero.
- fail_valid_o and fail_idx_o are computed from the captured codes over captured tiles only, valid in RUN and DONE. Uncaptured tiles count as zero.
- eoc_mask_o is live in every state.
- exit_code_o, timeout_o and the fail outputs are held in DONE until the next start. start clears them.
- Asynchronous reset at any time returns to IDLE and zeroes everything.

## Timing
- Start latency: with start_i high before edge k, busy_o=1 after edge k.
- A tile whose EOC is already high at start is captured at edge k+1, the first RUN cycle.
- EOC-to-done latency: if the last EOC is sampled at edge j, then after edge j done_o=1, busy_o=0 and the final mask and codes are visible.
- Outputs are registered or a combinational decode of registers. There is no combinational path from tile_eoc_i to done_o.
- N_TILES=1 must work, with IDX_W=1 and fail_idx_o=0.

## Test plan
- Basic completion: N=4, limit 0; start; EOCs arrive at cycles 3, 5, 5, 9, all with code 0 → done_o after the cycle-9 edge, exit_code_o=0, fail_valid_o=0, mask 4'b1111, timeout_o=0.
- Error aggregation: codes tile0=0, tile1=0x11, tile2=0, tile3=0x7 → exit_code_o=0x11, fail_idx_o=1, fail_valid_o=1.
- Timeout: limit 20; tiles 0 and 2 never assert EOC → done_o after exactly 20 RUN cycles, timeout_o=1, exit_code_o=0xFFFF_FFFF, mask 4'b1010.
- Tie: the last EOC lands on the limit-th RUN cycle → timeout_o=0 and the normal exit code is reported.
- Capture-once and restart:
  - tile1 asserts EOC with 0x5, then drops and re-asserts with 0x9 → captured 0x5;
  - start during RUN has no effect;
  - start in DONE clears the mask, fail outputs and timeout, and reruns correctly.
- Reset mid-RUN: assert rst_ni=0 asynchronously with 2 tiles captured → all outputs are 0 immediately. After release, the block stays IDLE until start.
